// File: rtl/joycon_pad_reader.sv
// joycon_pad_reader: polls an NES pad (4021 shift register) through its
// latch/clock/data wires and publishes a qualified 8-bit button state.
// Bit order of buttons: A, B, Select, Start, Up, Down, Left, Right (0..7),
// raw level (1 = released).
module joycon_pad_reader #(
  parameter int unsigned TICK_DIV      = 128,
  parameter int unsigned POLL_TICKS    = 2048,
  parameter int unsigned REQUIRE_MATCH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_req,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       frame_valid,
  output logic       busy
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = $clog2(POLL_TICKS);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETTLE, S_CLK_HI, S_CLK_LO, S_DONE
  } state_t;

  state_t        state_q;
  logic [1:0]    sync_q;
  logic [TW-1:0] tick_cnt_q;
  logic [PW-1:0] poll_cnt_q;
  logic          pend_q;
  logic          ph_q;
  logic [2:0]    bit_q;
  logic [7:0]    rx_q;
  logic [7:0]    prev_q;
  logic [7:0]    buttons_q;
  logic          latch_q;
  logic          pclk_q;
  logic          fv_q;
  logic          busy_q;

  logic tick;
  logic auto_hit;
  logic idle;
  logic want;
  logic sdat;

  assign tick     = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign auto_hit = tick && (poll_cnt_q == PW'(POLL_TICKS - 1));
  assign idle     = (state_q == S_IDLE);
  // A start is wanted if one is already pending, the poll timer fires now,
  // or software asks while idle. Coinciding sources merge into one read.
  assign want     = pend_q | auto_hit | (poll_req & idle);
  assign sdat     = sync_q[1];

  // Two-flop synchroniser for the asynchronous pad data line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], pad_data};
  end

  // Free-running phase tick and the automatic poll interval counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      poll_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
      poll_cnt_q <= auto_hit ? '0 : poll_cnt_q + 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // Read sequencer: latch, settle, 7 clock pulses, then an atomic publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pend_q    <= 1'b0;
      ph_q      <= 1'b0;
      bit_q     <= '0;
      rx_q      <= '0;
      prev_q    <= 8'hFF;
      buttons_q <= 8'hFF;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b0;
      fv_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      pend_q <= want;
      case (state_q)
        S_IDLE: begin
          if (tick && want) begin
            pend_q  <= 1'b0;
            state_q <= S_LATCH;
            latch_q <= 1'b1;
            busy_q  <= 1'b1;
            ph_q    <= 1'b0;
          end
        end
        S_LATCH: begin
          if (tick) begin
            if (ph_q) begin
              state_q <= S_SETTLE;
              latch_q <= 1'b0;
            end else begin
              ph_q <= 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (tick) begin
            rx_q[0] <= sdat;
            bit_q   <= 3'd1;
            state_q <= S_CLK_HI;
            pclk_q  <= 1'b1;
          end
        end
        S_CLK_HI: begin
          if (tick) begin
            state_q <= S_CLK_LO;
            pclk_q  <= 1'b0;
          end
        end
        S_CLK_LO: begin
          if (tick) begin
            rx_q[bit_q] <= sdat;
            if (bit_q == 3'd7) begin
              state_q <= S_DONE;
              fv_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              state_q <= S_CLK_HI;
              pclk_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          fv_q    <= 1'b0;
          busy_q  <= 1'b0;
          prev_q  <= rx_q;
          if (REQUIRE_MATCH == 0 || rx_q == prev_q) buttons_q <= rx_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pad_latch   = latch_q;
  assign pad_clk     = pclk_q;
  assign buttons     = buttons_q;
  assign frame_valid = fv_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_joycon_pad_reader.sv
// Bench for joycon_pad_reader: two instances (match required / not) share a
// behavioural 4021 pad; a monitor keeps per-read waveform stats and a
// reference model of what each instance should publish.
module tb_joycon_pad_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       poll_req = 1'b0;
  logic       pad_data;
  logic       pad_latch, pad_clk, frame_valid, busy;
  logic [7:0] buttons;
  logic       l0, c0, fv0, busy0;
  logic [7:0] btn0;

  always #5 clk = ~clk;

  joycon_pad_reader #(.TICK_DIV(4), .POLL_TICKS(32), .REQUIRE_MATCH(1)) dut1 (
    .clk(clk), .rst(rst), .poll_req(poll_req), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons),
    .frame_valid(frame_valid), .busy(busy));

  joycon_pad_reader #(.TICK_DIV(4), .POLL_TICKS(32), .REQUIRE_MATCH(0)) dut0 (
    .clk(clk), .rst(rst), .poll_req(poll_req), .pad_data(pad_data),
    .pad_latch(l0), .pad_clk(c0), .buttons(btn0),
    .frame_valid(fv0), .busy(busy0));

  // 4021 model: parallel load while latch is high, shift on clock rise,
  // serial input tied high. A disconnected pad is pulled up.
  logic [7:0] pad_val = 8'hFF;
  logic [7:0] sr = 8'hFF;
  logic       pclk_d = 1'b0;
  logic       connected = 1'b1;
  always @(posedge clk) begin
    if (pad_latch) sr <= pad_val;
    else if (pad_clk && !pclk_d) sr <= {1'b1, sr[7:1]};
    pclk_d <= pad_clk;
  end
  assign pad_data = connected ? sr[0] : 1'b1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-read stats and reference model of published values.
  int t_rise, t_fv, latch_hi, clk_rises, clk_hi, w, min_w, max_w, busy_n, fv_n;
  int fv_total = 0, rise_total = 0;
  logic latch_d = 1'b0, clk_d = 1'b0, busy_at_rise = 1'b0;
  logic [7:0] cap = 8'hFF, prev_m = 8'hFF, pub1 = 8'hFF, pub0 = 8'hFF;
  always @(negedge clk) begin
    if (rst) begin
      prev_m <= 8'hFF; pub1 <= 8'hFF; pub0 <= 8'hFF;
      fv_total <= 0; rise_total <= 0; latch_d <= 1'b0; clk_d <= 1'b0;
    end else begin
      latch_d <= pad_latch;
      clk_d   <= pad_clk;
      if (pad_latch && !latch_d) begin
        t_rise <= cyc; rise_total <= rise_total + 1; latch_hi <= 1;
        clk_rises <= 0; clk_hi <= 0; w <= 0; min_w <= 1000; max_w <= 0;
        busy_n <= busy ? 1 : 0; busy_at_rise <= busy; fv_n <= 0;
      end else begin
        if (pad_latch) latch_hi <= latch_hi + 1;
        if (busy) busy_n <= busy_n + 1;
        if (pad_clk) begin
          clk_hi <= clk_hi + 1;
          w <= w + 1;
          if (!clk_d) clk_rises <= clk_rises + 1;
        end else if (clk_d) begin
          if (w < min_w) min_w <= w;
          if (w > max_w) max_w <= w;
          w <= 0;
        end
        if (frame_valid) begin t_fv <= cyc; fv_n <= fv_n + 1; end
      end
      if (!pad_latch && latch_d) cap <= connected ? pad_val : 8'hFF;
      if (frame_valid) begin
        fv_total <= fv_total + 1;
        prev_m   <= cap;
        if (cap == prev_m) pub1 <= cap;
        pub0     <= cap;
      end
    end
  end

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_fv(input string nm);
    int n = 0;
    while (!frame_valid && n < 400) begin @(negedge clk); n++; end
    chk(nm, frame_valid, 1);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] v);
    pad_val = v;
    if (!busy) begin poll_req = 1'b1; @(negedge clk); poll_req = 1'b0; end
    wait_fv("read_done");
    chk("model_rm1", buttons, pub1);
    chk("model_rm0", btn0, pub0);
  endtask

  typedef struct { logic [7:0] pad; logic [7:0] exp1; logic [7:0] exp0; } vec_t;
  vec_t tbl[7];

  initial begin
    int r, c, n, k, d, exp_c;
    logic pc;
    logic [7:0] v, lastv;
    tbl[0] = '{8'hFE, 8'hFF, 8'hFE};
    tbl[1] = '{8'hFE, 8'hFE, 8'hFE};
    tbl[2] = '{8'h5A, 8'hFE, 8'h5A};
    tbl[3] = '{8'hA5, 8'hFE, 8'hA5};
    tbl[4] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[5] = '{8'hFF, 8'hA5, 8'hFF};
    tbl[6] = '{8'hFF, 8'hFF, 8'hFF};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_latch", pad_latch, 0);
    chk("rst_clk", pad_clk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_buttons", buttons, 8'hFF);
    chk("rst_buttons0", btn0, 8'hFF);
    rst = 1'b0;
    connected = 1'b0;

    // Disconnected pad read, with a poll_req dropped while busy
    poll_req = 1'b1; @(negedge clk); poll_req = 1'b0;
    n = 0;
    while (!pad_latch && n < 20) begin @(negedge clk); n++; end
    chk("latch_start", pad_latch, 1);
    repeat (20) @(negedge clk);
    chk("busy_mid", busy, 1);
    poll_req = 1'b1; @(negedge clk); poll_req = 1'b0;
    wait_fv("busy_read_done");
    repeat (40) @(negedge clk);
    chk("no_extra_read", rise_total, 1);
    chk("fv_once", fv_total, 1);
    chk("fv_width", fv_n, 1);
    chk("latch_width", latch_hi, 8);
    chk("clk_pulses", clk_rises, 7);
    chk("clk_hi_total", clk_hi, 28);
    chk("clk_min_w", min_w, 4);
    chk("clk_max_w", max_w, 4);
    chk("busy_at_rise", busy_at_rise, 1);
    chk("busy_span", busy_n, 69);
    chk("rise_to_fv", t_fv - t_rise, 68);
    chk("disc_buttons", buttons, 8'hFF);

    // poll_req in IDLE: latch rises at the next tick (tick phase known
    // from the previous latch rise, which follows a tick by one cycle)
    r = cyc;
    d = (r + 1 - t_rise) % 4;
    exp_c = r + 1 + ((d == 0) ? 0 : 4 - d);
    poll_req = 1'b1; @(negedge clk); poll_req = 1'b0;
    n = 0;
    while (!pad_latch && n < 20) begin @(negedge clk); n++; end
    c = cyc;
    chk("idle_poll_rise", c, exp_c);
    wait_fv("idle_read_done");
    connected = 1'b1;

    // Table: matched publish and glitch rejection
    for (int i = 0; i < 7; i++) begin
      do_read(tbl[i].pad);
      chk($sformatf("tbl%0d_rm1", i), buttons, tbl[i].exp1);
      chk($sformatf("tbl%0d_rm0", i), btn0, tbl[i].exp0);
    end

    // Random reads, biased to repeat so matched publishes happen
    lastv = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      v = ($urandom_range(0, 2) == 0) ? lastv : 8'($urandom);
      do_read(v);
      lastv = v;
    end

    // Reset mid-read
    do_read(8'h3C);
    do_read(8'h3C);
    chk("pre_rst_buttons", buttons, 8'h3C);
    pad_val = 8'h3C;
    if (!busy) begin poll_req = 1'b1; @(negedge clk); poll_req = 1'b0; end
    n = 0; k = 0; pc = pad_clk;
    while (k < 4 && n < 400) begin
      @(negedge clk); n++;
      if (pad_clk && !pc) k++;
      pc = pad_clk;
    end
    chk("mid_clk4", k, 4);
    chk("mid_clk_high", pad_clk, 1);
    rst = 1'b1;
    #1;
    chk("mrst_latch", pad_latch, 0);
    chk("mrst_clk", pad_clk, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_buttons", buttons, 8'hFF);
    chk("mrst_buttons0", btn0, 8'hFF);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mrst_no_pending", rise_total, 0);
    do_read(8'h96);
    chk("post1_rm1", buttons, 8'hFF);
    chk("post1_rm0", btn0, 8'h96);
    do_read(8'h96);
    chk("post2_rm1", buttons, 8'h96);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/joycon_pad_reader.md
# joycon_pad_reader

Polls a physical NES controller (4021 parallel-in/serial-out shift register) over its latch/clock/data wires and produces the 8-bit button state consumed by the CPU-side joycon register block (its `joycon_ctrl_input`). The block generates the latch and clock pulses, synchronises and samples the serial data, and qualifies each read before publishing it. Polling is periodic, and software or a frame timer can also trigger a read on demand.

## Interface
- `TICK_DIV`, default 128: clk cycles per pad phase tick; minimum 4.
- `POLL_TICKS`, default 2048: ticks between automatic poll starts; minimum 20.
- `REQUIRE_MATCH`, default 1: 1 = publish only when two consecutive reads agree; 0 = publish every read.

- `clk`  in  1  system clock; the single clock for the block.
- `rst`  in  1  asynchronous, active-high reset.
- `poll_req`  in  1  single-cycle request for an immediate poll.
- `pad_data`  in  1  serial data from the pad, asynchronous, raw level (0 = pressed).
- `pad_latch`  out  1  4021 parallel-load strobe, registered.
- `pad_clk`  out  1  4021 shift clock, registered.
- `buttons`  out  8  published state, raw level (1 = released). Bit order is A, B, Select, Start, Up, Down, Left, Right at bits 0..7.
- `frame_valid`  out  1  one-cycle pulse on each completed read.
- `busy`  out  1  high while a read is in progress.

## Operation
- `pad_data` passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick` is asserted in the cycle where the count equals TICK_DIV-1.
- Poll counter:
  - Advances on each `tick` and wraps at POLL_TICKS-1.
  - Reaching POLL_TICKS-1 raises a pending start.
- `poll_req` sets the pending start only while the FSM is IDLE. It is ignored while `busy`.
- FSM states, with all transitions taken on `tick`:
  - IDLE: latch=0, clk=0. If a start is pending, clear it and go to LATCH.
  - LATCH: latch=1 for 2 ticks, then go to SETTLE.
  - SETTLE: latch=0 for 1 tick. At the end of this tick, sample into rx[0], then go to CLK_HI.
  - CLK_HI: clk=1 for 1 tick, then go to CLK_LO.
  - CLK_LO: clk=0 for 1 tick. At the end of this tick, sample into rx[n] (n = 1..7).
    - If n<7, go to CLK_HI.
    - If n=7, go to DONE.
  - DONE: lasts 1 clk cycle, not a tick.
    - Pulse `frame_valid`.
    - Publish `rx` to `buttons` if REQUIRE_MATCH=0 or rx equals the previous read.
    - Store rx as the previous read.
    - Go to IDLE.
- A disconnected pad (pulled up) reads 8'hFF, which is all released.
- `buttons` never changes mid-read. The update is atomic in DONE only.
- Reset, including mid-read:
  - Outputs go to reset values immediately.
  - FSM goes to IDLE.
  - Counters, rx and the previous read are cleared (previous read = 8'hFF).
  - The pending start is cleared.
  - No partial data is published.

## Timing
- Reset values:
  - pad_latch=0, pad_clk=0, busy=0, frame_valid=0.
  - buttons=8'hFF.
- Pad phase timing:
  - Latch high width = 2·TICK_DIV clk cycles.
  - Each pad_clk high width = TICK_DIV cycles.
  - Exactly 7 pad_clk pulses per read.
- Read duration: 17 ticks from the latch rising edge to the rx[7] sample, plus 1 cycle to `frame_valid`.
- Sample point: the last cycle of a tick, which is at least TICK_DIV-1 cycles after the preceding pin edge. This exceeds the synchroniser latency of 2 cycles.
- `busy` is high from the cycle `pad_latch` rises through the DONE cycle inclusive.
- `buttons` updates in the cycle after DONE, simultaneously with `frame_valid` falling.
- Publish latency: a stable press appears after 1 read (REQUIRE_MATCH=0) or after 2 reads (REQUIRE_MATCH=1).
- Poll timing:
  - `poll_req` in IDLE: pad_latch rises at the next `tick`.
  - If the automatic pending start and `poll_req` coincide, one read is performed.

## Test plan
All scenarios use TICK_DIV=4, POLL_TICKS=32 and a behavioural 4021 pad model.

- **Reset values:** assert rst for 3 cycles -> pad_latch=0, pad_clk=0, busy=0, frame_valid=0, buttons=8'hFF.
- **Matched publish:** pad holds 8'hFE (A pressed), REQUIRE_MATCH=1 -> buttons stays FF after read 1 and becomes FE after read 2. Also check that frame_valid pulses once per read.
- **Waveform:** per read, pad_latch is high for exactly 8 cycles and there are 7 pad_clk pulses of 4 cycles each. The last sample is 68 cycles after the latch rises, and busy spans 69 cycles.
- **Glitch rejection:** pad reads 5A, A5, A5 with REQUIRE_MATCH=1 -> buttons stays FF after the first two reads and becomes A5 after the third. With REQUIRE_MATCH=0, buttons follows every read.
- **poll_req handling:**
  - poll_req in IDLE -> latch rises at the next tick.
  - poll_req pulsed while busy -> no extra read follows.
- **Reset mid-read:** assert rst while sampling bit 4 -> pad_latch and pad_clk go to 0 asynchronously and buttons=FF. After release, the next read completes all 8 bits and publishes correctly.
